vga_pixel_fetch: RTL and testbench

Parametrised framebuffer-to-VGA pixel pipeline between the VGA timing controller and the framebuffer block RAM. It maps display coordinates to a scaled, offset image window, issues the RAM read address, and expands packed RGB pixels to full-width DAC channels. Sync and blank are delay-matched to the RAM read latency. Outside the image window it drives a programmable border colour.

---
 rtl/vga_pixel_fetch.sv | 166 ++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Framebuffer-to-VGA pixel pipeline: window mapping, RAM addressing, channel expansion, border fill.
// Latency RAM_LAT+2 cycles for rgb/syncs/blank_n_out; ram_address one cycle after inputs.
// No backpressure: streams one pixel per clock. VGA_FETCH_TESTPAT_EN adds a test_mode colour-bar source.
module vga_pixel_fetch #(
   parameter int XB      = 8,
   parameter int YB      = 8,
   parameter int COL_W   = 12,
   parameter int ROW_W   = 11,
   parameter int CH_W    = 5,
   parameter int OUT_W   = 8,
   parameter int RAM_LAT = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [COL_W-1:0]     display_col,
   input  logic [ROW_W-1:0]     display_row,
   input  logic                 visible,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic [COL_W-1:0]     origin_x,
   input  logic [ROW_W-1:0]     origin_y,
   input  logic [1:0]           scale,
   input  logic [3*OUT_W-1:0]   border_rgb,
`ifdef VGA_FETCH_TESTPAT_EN
   input  logic                 test_mode,
`endif
   output logic [XB+YB-1:0]     ram_address,
   input  logic [3*CH_W-1:0]    ram_q,
   output logic [OUT_W-1:0]     red,
   output logic [OUT_W-1:0]     green,
   output logic [OUT_W-1:0]     blue,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 blank_n_out
);

   localparam int D = RAM_LAT + 1;

   // Window configuration only changes at the start of a vertical sync pulse.
   logic                 vsync_q;
   logic [COL_W-1:0]     sh_origin_x;
   logic [ROW_W-1:0]     sh_origin_y;
   logic [1:0]           sh_scale;
   logic [3*OUT_W-1:0]   sh_border;

   always_ff @(posedge clock) begin
      vsync_q <= vsync_in;
      if (reset || (vsync_q && !vsync_in)) begin
         sh_origin_x <= origin_x;
         sh_origin_y <= origin_y;
         sh_scale    <= scale;
         sh_border   <= border_rgb;
      end
   end

   logic [COL_W:0]   dx_full;
   logic [ROW_W:0]   dy_full;
   logic [COL_W-1:0] dx_s;
   logic [ROW_W-1:0] dy_s;
   logic             in_win;

   assign dx_full = {1'b0, display_col} - {1'b0, sh_origin_x};
   assign dy_full = {1'b0, display_row} - {1'b0, sh_origin_y};
   assign dx_s    = dx_full[COL_W-1:0] >> sh_scale;
   assign dy_s    = dy_full[ROW_W-1:0] >> sh_scale;
   // Top bit of each difference is the borrow: left of / above the window.
   assign in_win  = visible & ~dx_full[COL_W] & ~dy_full[ROW_W]
                  & ((dx_s >> XB) == '0) & ((dy_s >> YB) == '0);

   always_ff @(posedge clock) begin
      if (reset)
         ram_address <= '0;
      else if (in_win)
         ram_address <= {dx_s[XB-1:0], dy_s[YB-1:0]};
   end

   logic [D-1:0] dl_vis;
   logic [D-1:0] dl_win;
   logic [D-1:0] dl_hs;
   logic [D-1:0] dl_vs;

   always_ff @(posedge clock) begin
      if (reset) begin
         dl_vis <= '0;
         dl_win <= '0;
         dl_hs  <= '1;
         dl_vs  <= '1;
      end else begin
         dl_vis <= {dl_vis[D-2:0], visible};
         dl_win <= {dl_win[D-2:0], in_win};
         dl_hs  <= {dl_hs[D-2:0], hsync_in};
         dl_vs  <= {dl_vs[D-2:0], vsync_in};
      end
   end

`ifdef VGA_FETCH_TESTPAT_EN
   logic [D-1:0]   dl_tm;
   logic [3*D-1:0] dl_bar;
   logic [2:0]     bar;

   assign bar = dl_bar[3*D-1 -: 3];

   always_ff @(posedge clock) begin
      if (reset) begin
         dl_tm  <= '0;
         dl_bar <= '0;
      end else begin
         dl_tm  <= {dl_tm[D-2:0], test_mode};
         dl_bar <= {dl_bar[3*D-4:0], dx_s[XB-1 -: 3]};
      end
   end
`endif

   // MSB replication: full-scale stored value maps to full-scale DAC code.
   function automatic logic [OUT_W-1:0] expand(input logic [CH_W-1:0] c);
      logic [OUT_W-1:0] o;
      o = '0;
      for (int i = 0; i < OUT_W; i++)
         o[OUT_W-1-i] = c[CH_W-1-(i % CH_W)];
      return o;
   endfunction

   logic [OUT_W-1:0] pix_r, pix_g, pix_b;

   always_comb begin
      pix_r = expand(ram_q[3*CH_W-1 -: CH_W]);
      pix_g = expand(ram_q[2*CH_W-1 -: CH_W]);
      pix_b = expand(ram_q[CH_W-1:0]);
`ifdef VGA_FETCH_TESTPAT_EN
      if (dl_tm[D-1]) begin
         pix_r = {OUT_W{bar[2]}};
         pix_g = {OUT_W{bar[1]}};
         pix_b = {OUT_W{bar[0]}};
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         hsync_out   <= 1'b1;
         vsync_out   <= 1'b1;
         blank_n_out <= 1'b0;
      end else begin
         hsync_out   <= dl_hs[D-1];
         vsync_out   <= dl_vs[D-1];
         blank_n_out <= dl_vis[D-1];
         if (dl_vis[D-1] && dl_win[D-1]) begin
            red   <= pix_r;
            green <= pix_g;
            blue  <= pix_b;
         end else if (dl_vis[D-1]) begin
            red   <= sh_border[3*OUT_W-1 -: OUT_W];
            green <= sh_border[2*OUT_W-1 -: OUT_W];
            blue  <= sh_border[OUT_W-1:0];
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with default parameters and a one-cycle-latency RAM model.
module tb_vga_pixel_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] display_col;
   logic [10:0] display_row;
   logic        visible;
   logic        hsync_in;
   logic        vsync_in;
   logic [11:0] origin_x;
   logic [10:0] origin_y;
   logic [1:0]  scale;
   logic [23:0] border_rgb;
`ifdef VGA_FETCH_TESTPAT_EN
   logic        test_mode;
`endif
   logic [15:0] ram_address;
   logic [14:0] ram_q;
   logic [7:0]  red, green, blue;
   logic        hsync_out, vsync_out, blank_n_out;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   vga_pixel_fetch dut (
      .clock       (clock),
      .reset       (reset),
      .display_col (display_col),
      .display_row (display_row),
      .visible     (visible),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .origin_x    (origin_x),
      .origin_y    (origin_y),
      .scale       (scale),
      .border_rgb  (border_rgb),
`ifdef VGA_FETCH_TESTPAT_EN
      .test_mode   (test_mode),
`endif
      .ram_address (ram_address),
      .ram_q       (ram_q),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .blank_n_out (blank_n_out)
   );

   function automatic logic [14:0] ram_fn(input logic [15:0] a);
      case (a)
         16'h0503: ram_fn = 15'h7FFF;
         16'h0707: ram_fn = 15'h403F;
         default:  ram_fn = 15'h0000;
      endcase
   endfunction

   always @(posedge clock) ram_q <= ram_fn(ram_address);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int col, input int row, input logic vis,
                        input logic hs, input logic vs);
      display_col = 12'(col);
      display_row = 11'(row);
      visible     = vis;
      hsync_in    = hs;
      vsync_in    = vs;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      origin_x   = 12'd0;
      origin_y   = 11'd0;
      scale      = 2'd0;
      border_rgb = 24'h123456;
`ifdef VGA_FETCH_TESTPAT_EN
      test_mode  = 1'b0;
`endif
      drive(5, 3, 1'b1, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk("rst_red", 32'(red), 32'h00);
      chk("rst_blue", 32'(blue), 32'h00);
      chk("rst_hsync", 32'(hsync_out), 32'h1);
      chk("rst_vsync", 32'(vsync_out), 32'h1);
      chk("rst_blank", 32'(blank_n_out), 32'h0);
      chk("rst_addr", 32'(ram_address), 32'h0000);

      // single white pixel at (5,3) with an hsync low in the same cycle
      reset = 1'b0;
      drive(5, 3, 1'b1, 1'b0, 1'b1);
      tick();
      chk("lat_addr", 32'(ram_address), 32'h0503);
      drive(0, 0, 1'b0, 1'b1, 1'b1);
      tick();
      chk("lat_early_blank", 32'(blank_n_out), 32'h0);
      chk("lat_early_hsync", 32'(hsync_out), 32'h1);
      tick();
      chk("lat_red", 32'(red), 32'hFF);
      chk("lat_green", 32'(green), 32'hFF);
      chk("lat_blue", 32'(blue), 32'hFF);
      chk("lat_hsync", 32'(hsync_out), 32'h0);
      chk("lat_blank", 32'(blank_n_out), 32'h1);
      tick();
      chk("lat_after_blank", 32'(blank_n_out), 32'h0);
      chk("lat_after_red", 32'(red), 32'h00);
      chk("lat_after_hsync", 32'(hsync_out), 32'h1);

      // channel expansion of 10000_00001_11111
      drive(7, 7, 1'b1, 1'b1, 1'b1);
      tick(); tick(); tick();
      chk("exp_red", 32'(red), 32'h84);
      chk("exp_green", 32'(green), 32'h08);
      chk("exp_blue", 32'(blue), 32'hFF);

      // scale change mid-frame waits for the vsync falling edge
      scale = 2'd2;
      drive(40, 20, 1'b1, 1'b1, 1'b1);
      tick();
      chk("shadow_hold_1x", 32'(ram_address), 32'h2814);
      drive(40, 20, 1'b0, 1'b1, 1'b0);
      tick();
      drive(40, 20, 1'b1, 1'b1, 1'b1);
      tick();
      chk("shadow_4x", 32'(ram_address), 32'h0A05);
      tick();
      chk("vsync_out_low", 32'(vsync_out), 32'h0);
      tick();
      chk("vsync_out_high", 32'(vsync_out), 32'h1);

      // window at (100,50), 2x, new border
      origin_x   = 12'd100;
      origin_y   = 11'd50;
      scale      = 2'd1;
      border_rgb = 24'hA5C3E7;
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(103, 55, 1'b1, 1'b1, 1'b1);
      tick();
      chk("off_addr", 32'(ram_address), 32'h0102);
      drive(99, 55, 1'b1, 1'b1, 1'b1);
      tick();
      chk("left_addr_hold", 32'(ram_address), 32'h0102);
      tick(); tick();
      chk("left_border_r", 32'(red), 32'hA5);
      chk("left_border_g", 32'(green), 32'hC3);
      chk("left_border_b", 32'(blue), 32'hE7);

      // last image column (dx>>1 == 255) is inside, the next one is not
      drive(611, 55, 1'b1, 1'b1, 1'b1);
      tick();
      chk("edge_in_addr", 32'(ram_address), 32'hFF02);
      drive(612, 55, 1'b1, 1'b1, 1'b1);
      tick();
      chk("edge_out_addr_hold", 32'(ram_address), 32'hFF02);
      tick();
      chk("edge_in_pixel", 32'({red, green, blue}), 32'h000000);
      tick();
      chk("edge_out_border", 32'({red, green, blue}), 32'hA5C3E7);

      // origin past the display extent: border everywhere
      origin_x = 12'd4000;
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(2000, 55, 1'b1, 1'b1, 1'b1);
      tick(); tick(); tick();
      chk("far_origin_border", 32'({red, green, blue}), 32'hA5C3E7);
      chk("far_origin_blank", 32'(blank_n_out), 32'h1);

`ifdef VGA_FETCH_TESTPAT_EN
      origin_x  = 12'd0;
      origin_y  = 11'd0;
      scale     = 2'd0;
      test_mode = 1'b1;
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(32, 0, 1'b1, 1'b1, 1'b1);
      tick(); tick(); tick();
      chk("tp_bar1", 32'({red, green, blue}), 32'h0000FF);
      drive(224, 0, 1'b1, 1'b1, 1'b1);
      tick(); tick(); tick();
      chk("tp_bar7", 32'({red, green, blue}), 32'hFFFFFF);
`endif

      // reset in the middle of active video clears outputs on the next edge
      reset = 1'b1;
      tick();
      chk("midrst_blank", 32'(blank_n_out), 32'h0);
      chk("midrst_rgb", 32'({red, green, blue}), 32'h000000);
      chk("midrst_hsync", 32'(hsync_out), 32'h1);
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
